// File: rtl/ss_pkg.sv
// ---------------------------------------------------------------------------
// ss_pkg
// Shared types and constants for the Serie_Serie shift sequencer.
//   state_t   : sequencer FSM states (IDLE, SHIFT, DONE)
//   DIR_RIGHT : shift direction right, LSB first
//   DIR_LEFT  : shift direction left, MSB first
//   SS_WIDTH  : default SISO register / parallel word width, shared with
//               Serie_Serie_Register
// ---------------------------------------------------------------------------
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    localparam int SS_WIDTH = 8;

endpackage

// File: rtl/ss_shift_sequencer.sv
// ---------------------------------------------------------------------------
// ss_shift_sequencer
// Sequences a serial-in/serial-out shift register through one exchange pass
// of exactly WIDTH shifts per accepted request. The parallel word is
// streamed into the register while the WIDTH bits leaving it are captured
// into data_out.
//
// Ports:
//   clock        : rising-edge clock
//   reset        : synchronous, active-high reset
//   start        : pass request, sampled only in IDLE
//   dir          : pass direction (0 right/LSB first, 1 left/MSB first)
//   stall        : freezes the pass for the current SHIFT cycle
//   data_in      : word to load, latched on acceptance
//   busy         : high from the cycle after acceptance through DONE
//   done         : one-cycle completion pulse
//   data_out     : captured old register contents
//   sr_in        : serial data to the SISO in pin
//   sr_enable    : SISO enable pin
//   sr_leftright : SISO leftright pin (latched direction)
//   sr_out       : serial data from the SISO out pin
//   dbg_state_o  : current FSM state, for observation only
//
// Request handshake: start acts as a valid with an implicit ready that is
// high only in IDLE. A request is accepted on the edge where start=1 and
// the FSM is in IDLE; start in SHIFT or DONE is dropped, never queued.
// ---------------------------------------------------------------------------
module ss_shift_sequencer
    import ss_pkg::*;
#(
    parameter  int WIDTH = SS_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             stall,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             sr_in,
    output logic             sr_enable,
    output logic             sr_leftright,
    input  logic             sr_out,
    output state_t           dbg_state_o
);

    localparam int               IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   load_q, load_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   bit_idx;

    // Both the outgoing load bit and the capture slot use the same position:
    // cnt for right passes, mirrored for left passes. cnt never exceeds
    // WIDTH-1 while in SHIFT, so truncation to IDX_W bits is lossless.
    always_comb begin
        if (dir_q == DIR_LEFT) begin
            bit_idx = IDX_W'(LAST - cnt_q);
        end else begin
            bit_idx = cnt_q[IDX_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        dir_d     = dir_q;
        dout_d    = dout_q;
        sr_enable = 1'b0;
        sr_in     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    load_d  = data_in;
                    dir_d   = dir;
                    cnt_d   = '0;
                    dout_d  = '0;
                end
            end
            SHIFT: begin
                sr_enable = ~stall;
                sr_in     = load_q[bit_idx];
                if (!stall) begin
                    // sr_out is the register's current edge bit, i.e. the bit
                    // that leaves on this same edge.
                    dout_d[bit_idx] = sr_out;
                    cnt_d           = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            dir_q   <= DIR_RIGHT;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign data_out     = dout_q;
    assign sr_leftright = dir_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ss_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ss_shift_sequencer
// Directed bench for ss_shift_sequencer at WIDTH=8 with a behavioural SISO
// register attached to the sr_* pins. Inputs are driven and outputs sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ss_shift_sequencer;
    import ss_pkg::*;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic         dir;
    logic         stall;
    logic [W-1:0] data_in;
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;
    logic         sr_in;
    logic         sr_enable;
    logic         sr_leftright;
    logic         sr_out;
    state_t       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    ss_shift_sequencer #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .dir          (dir),
        .stall        (stall),
        .data_in      (data_in),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .sr_in        (sr_in),
        .sr_enable    (sr_enable),
        .sr_leftright (sr_leftright),
        .sr_out       (sr_out),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural SISO register ----------------
    // out pin is the flop that leaves on the next enabled edge.
    logic [W-1:0] siso_q = '0;
    always @(posedge clock) begin
        if (sr_enable) begin
            if (sr_leftright) siso_q <= {siso_q[W-2:0], sr_in};
            else              siso_q <= {sr_in, siso_q[W-1:1]};
        end
    end
    assign sr_out = sr_leftright ? siso_q[W-1] : siso_q[0];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One pass: optional stall burst after stall_after shifts, and optional
    // ignored start pulses at shift 5 and in the DONE cycle.
    task automatic run_pass(input logic [W-1:0] data, input logic d,
                            input int stall_after, input int stall_len,
                            input bit extra, input int exp_lat,
                            input logic [W-1:0] exp_out);
        int           lat;
        int           shifts;
        int           stalls;
        bit           got_done;
        bit           poked;
        logic         exp_bit;
        logic [W-1:0] exp;
        exp_q.push_back(exp_out);
        @(negedge clock);
        start   = 1'b1;
        data_in = data;
        dir     = d;
        lat = 0; shifts = 0; stalls = 0; got_done = 0; poked = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
            stall = 1'b0;
            if (done) begin
                got_done = 1;
            end else begin
                if (shifts == stall_after && stalls < stall_len) begin
                    stall = 1'b1;
                    stalls++;
                end
                if (extra && shifts == 5 && !poked) begin
                    start = 1'b1;
                    poked = 1;
                end
                #1;
                exp_bit = (shifts < W) ? (d ? data[W-1-shifts] : data[shifts]) : 1'b0;
                check_eq("sr_enable", sr_enable, !stall);
                if (!stall) check_eq("sr_in", sr_in, exp_bit);
                check_eq("busy_in_shift", busy, 1'b1);
                if (!stall) shifts++;
            end
        end
        stall = 1'b0;
        check_eq("done_seen", got_done, 1'b1);
        check_eq("latency", lat, exp_lat);
        check_eq("sr_leftright", sr_leftright, d);
        check_eq("busy_in_done", busy, 1'b1);
        exp = exp_q.pop_front();
        check_eq("data_out", data_out, exp);
        if (extra) start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        #1;
        check_eq("done_pulse_end", done, 1'b0);
        check_eq("busy_fall", busy, 1'b0);
        check_eq("state_idle", dbg_state, IDLE);
        check_eq("data_out_hold", data_out, exp);
        if (extra) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            check_eq("no_requeue_busy", busy, 1'b0);
            check_eq("no_requeue_enable", sr_enable, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int en_count;
        int done_count;
        reset   = 1'b1;
        start   = 1'b0;
        dir     = 1'b0;
        stall   = 1'b0;
        data_in = '0;

        // 1. reset held 2 cycles, then idle with stall toggling
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_sr_in", sr_in, 1'b0);
        check_eq("rst_sr_enable", sr_enable, 1'b0);
        check_eq("rst_sr_leftright", sr_leftright, 1'b0);
        check_eq("rst_state", dbg_state, IDLE);
        en_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            stall = i[0];
            #1;
            if (sr_enable || busy) en_count++;
        end
        stall = 1'b0;
        check_eq("idle_no_activity", en_count, 0);

        // 2. right pass onto cleared register
        run_pass(8'hA5, 1'b0, -1, 0, 1'b0, 9, 8'h00);
        // 3. back-to-back exchanges
        run_pass(8'h3C, 1'b0, -1, 0, 1'b0, 9, 8'hA5);
        run_pass(8'hFF, 1'b1, -1, 0, 1'b0, 9, 8'h3C);
        // 4. stall 3 cycles after the 4th shift
        run_pass(8'h5A, 1'b0, 4, 3, 1'b0, 12, 8'hFF);
        // 5. ignored start requests at shift 5 and in DONE
        run_pass(8'h81, 1'b1, -1, 0, 1'b1, 9, 8'h5A);

        // 6. reset after 4 shifts
        @(negedge clock);
        start   = 1'b1;
        data_in = 8'hC3;
        dir     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        check_eq("midrst_state", dbg_state, IDLE);
        check_eq("midrst_sr_enable", sr_enable, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_leftright", sr_leftright, 1'b0);
        reset = 1'b0;
        done_count = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            #1;
            if (done) done_count++;
        end
        check_eq("midrst_no_done", done_count, 0);
        check_eq("midrst_data_out", data_out, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ss_shift_sequencer.md
# ss_shift_sequencer

Controller that sequences the serial-in/serial-out shift register (SISO) in the Serie_Serie design. On each accepted request it performs one exchange pass of exactly WIDTH shifts. During the pass it streams a parallel word into the register one bit per enabled cycle, in the requested direction. At the same time it captures the WIDTH bits leaving the register into a parallel result word. It owns the register's `enable` and `leftright` controls, so the register never shifts outside a sequenced pass.

## Interface
- `WIDTH`, default 8: SISO register length and parallel word width; legal values are at least 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the shift counter; derived, never overridden.

Ports:
- `clock`, input, 1: the single clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a pass; only sampled in IDLE.
- `dir`, input, 1: direction for the pass; 0 = right, LSB first; 1 = left, MSB first; latched when `start` is accepted.
- `stall`, input, 1: when high during SHIFT, the pass freezes for that cycle.
- `data_in`, input, WIDTH: word to load; latched when `start` is accepted.
- `busy`, output, 1: high from the cycle after acceptance through the DONE cycle.
- `done`, output, 1: one-cycle pulse marking that the pass is complete.
- `data_out`, output, WIDTH: captured old register contents; stable from `done` until the next acceptance.
- `sr_in`, output, 1: serial data to the SISO `in` pin.
- `sr_enable`, output, 1: drives the SISO `enable` pin.
- `sr_leftright`, output, 1: drives the SISO `leftright` pin; equals the latched `dir`.
- `sr_out`, input, 1: serial data from the SISO `out` pin, which is registered inside the SISO.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
  - IDLE goes to SHIFT when `start` is 1. On that edge the block latches `data_in` into `load_q` and `dir` into `dir_q`, clears the counter to 0, and clears `data_out` to 0.
  - SHIFT goes to DONE on the edge where an unstalled shift takes the counter to WIDTH.
  - DONE goes to IDLE unconditionally after 1 cycle.
- SHIFT behaviour:
  - `sr_enable = ~stall`.
  - `sr_in` = `load_q[cnt]` when `dir_q=0`, or `load_q[WIDTH-1-cnt]` when `dir_q=1`.
  - On each unstalled edge the block stores `sr_out` into `data_out[cnt]` (`dir_q=0`) or `data_out[WIDTH-1-cnt]` (`dir_q=1`), then increments `cnt`.
- The sample-before-shift rule applies: the `sr_out` value captured on an edge is the bit leaving the register on that same edge.
- Outside SHIFT, `sr_enable=0` and `sr_in=0`.
- `sr_leftright` holds `dir_q` at all times, including in IDLE, so the direction pin never glitches mid-pass.
- Boundary conditions:
  - `start` while busy is ignored and not queued.
  - `start` in the DONE cycle is ignored. The earliest acceptance is the first IDLE cycle after DONE.
  - `stall` in IDLE or DONE has no effect.
  - `stall` held indefinitely freezes the pass, with `busy` held high. Nothing is lost.
  - `stall` rising on the cycle that would perform the final shift delays DONE by one cycle per stalled cycle.
  - `reset` mid-pass forces IDLE on that edge and drops `sr_enable` the same edge. The SISO contents are then undefined to upper layers.
- Arithmetic: `cnt` is unsigned CNT_W bits, counts 0..WIDTH, and never wraps.

## Timing
- Reset values: state=IDLE, `busy=0`, `done=0`, `data_out=0`, `sr_in=0`, `sr_enable=0`, `sr_leftright=0`, `cnt=0`, `load_q=0`, `dir_q=0`.
- Outputs:
  - `busy`, `done`, `data_out` and `sr_leftright` are registered.
  - `sr_enable` and `sr_in` are combinational from state, `cnt`, `load_q`, `dir_q` and `stall`. `stall` is the only input-to-output path.
- Latency:
  - With no stall, `start` is accepted at edge 0, shifts occur at edges 1..WIDTH, and `done`=1 during the cycle after edge WIDTH.
  - Total acceptance-to-done is WIDTH+1 cycles, plus one cycle per stalled SHIFT cycle.
- Throughput: one pass per WIDTH+2 cycles, because of the mandatory DONE→IDLE cycle.

## Structure
- Package `ss_pkg` holds:
  - `state_t` enum {IDLE, SHIFT, DONE}.
  - `DIR_RIGHT=1'b0` and `DIR_LEFT=1'b1`.
  - The default `WIDTH`, shared with Serie_Serie_Register.
- There is no sub-module; the counter and FSM stay in one module.
- The Tiny Tapeout top instantiates this block beside Serie_Serie_Register and connects `sr_*` to its `in`, `enable`, `leftright` and `out` pins.

## Test plan
Every scenario uses WIDTH=8, with a behavioural SISO model in the bench.
1. Reset, then idle: after `reset` is held for 2 cycles, all outputs are 0 and `start=0` produces no `sr_enable` activity for 20 cycles.
2. Right pass onto a cleared register:
   - Stimulus: `data_in`=8'hA5, `dir`=0, `start` pulse.
   - `sr_in` sequence is 1,0,1,0,0,1,0,1.
   - `done` occurs 9 cycles after acceptance.
   - `data_out`=8'h00.
3. Back-to-back exchange: a second pass with 8'h3C and `dir`=0 returns `data_out`=8'hA5. A third pass with `dir`=1 and 8'hFF returns the 8'h3C bits in MSB-first capture order, matching the model.
4. Stall: assert `stall` for 3 cycles after the 4th shift. `sr_enable` drops for exactly those cycles, `done` arrives at 12 cycles, and `data_out` is unchanged versus the unstalled result.
5. Ignored requests: pulse `start` at shift 5 and during DONE. Exactly one pass occurs, and `busy` falls one cycle after `done`.
6. Reset mid-pass: assert `reset` at shift 4. On the next edge state is IDLE and `sr_enable=0`; `done` never pulses and `data_out`=0.
